// File: rtl/bpf_stage2_if.sv
// AXI-Stream style bundles used by bpf_stage2.
//   bpf_stage2_if    : packet data stream (tdata/tkeep/tvalid/tlast/tuser, tready back)
//   bpf_stage2_ps_if : 8-bit per-packet status stream (tdata/tvalid, tready back)
interface bpf_stage2_if #(
  parameter int unsigned DATA_WIDTH = 512
);
  localparam int unsigned KEEP_WIDTH = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tlast;
  logic                  tuser;
  logic                  tready;

  modport master (output tdata, output tkeep, output tvalid, output tlast, output tuser,
                  input tready);
  modport slave  (input tdata, input tkeep, input tvalid, input tlast, input tuser,
                  output tready);
endinterface

interface bpf_stage2_ps_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/bpf_stage2.sv
// bpf_stage2: bad-packet filter, second stage.
// Buffers packet beats in a data FIFO and per-packet status in a status FIFO;
// good packets are forwarded on axis_tx, bad packets are discarded whole.
// Ports:
//   clk, resetn          : clock, asynchronous active-low reset
//   axis_rx  (slave)     : packet data from stage 1 (tuser ignored)
//   axis_ps  (slave)     : packet status, tdata[0] = bad
//   axis_tx  (master)    : forwarded clean packets (tuser always 0)
//   PASS_COUNT/DROP_COUNT: forwarded / dropped packet counters (wrapping)
module bpf_stage2 #(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned FIFO_DEPTH = 64,
  parameter int unsigned PS_DEPTH   = 16
) (
  input  logic                clk,
  input  logic                resetn,
  bpf_stage2_if.slave         axis_rx,
  bpf_stage2_ps_if.slave      axis_ps,
  bpf_stage2_if.master        axis_tx,
  output logic [31:0]         PASS_COUNT,
  output logic [31:0]         DROP_COUNT
);

  localparam int unsigned KEEP_W  = DATA_WIDTH / 8;
  localparam int unsigned ENTRY_W = DATA_WIDTH + KEEP_W + 1;
  localparam int unsigned DAW     = $clog2(FIFO_DEPTH);
  localparam int unsigned PAW     = $clog2(PS_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_PASS, S_DROP} state_t;

  state_t             state_q, state_d;
  logic               run_q;
  logic [DAW:0]       d_wr_q, d_rd_q;
  logic [PAW:0]       p_wr_q, p_rd_q;
  logic [ENTRY_W-1:0] d_mem [FIFO_DEPTH];
  logic               p_mem [PS_DEPTH];

  logic               data_empty, data_full, ps_empty, ps_full;
  logic               d_push, d_pop, p_push, p_pop;
  logic               tx_valid, pass_inc, drop_inc;
  logic [ENTRY_W-1:0] head;
  logic               head_last, ps_head;

  logic unused_ok;
  assign unused_ok = ^{axis_rx.tuser, axis_ps.tdata[7:1]};

  // Occupancy flags from extra-MSB pointers
  assign data_empty = (d_wr_q == d_rd_q);
  assign data_full  = (d_wr_q[DAW] != d_rd_q[DAW]) && (d_wr_q[DAW-1:0] == d_rd_q[DAW-1:0]);
  assign ps_empty   = (p_wr_q == p_rd_q);
  assign ps_full    = (p_wr_q[PAW] != p_rd_q[PAW]) && (p_wr_q[PAW-1:0] == p_rd_q[PAW-1:0]);

  // run_q keeps both readies low during reset and for the release cycle
  assign axis_rx.tready = run_q & ~data_full;
  assign axis_ps.tready = run_q & ~ps_full;
  assign d_push         = axis_rx.tvalid & axis_rx.tready;
  assign p_push         = axis_ps.tvalid & axis_ps.tready;

  assign head      = d_mem[d_rd_q[DAW-1:0]];
  assign head_last = head[0];
  assign ps_head   = p_mem[p_rd_q[PAW-1:0]];

  // FIFO storage: no reset needed, pointers define validity
  always_ff @(posedge clk) begin
    if (d_push) d_mem[d_wr_q[DAW-1:0]] <= {axis_rx.tdata, axis_rx.tkeep, axis_rx.tlast};
    if (p_push) p_mem[p_wr_q[PAW-1:0]] <= axis_ps.tdata[0];
  end

  // Pointers, counters, run flag and FSM state
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      run_q      <= 1'b0;
      d_wr_q     <= '0;
      d_rd_q     <= '0;
      p_wr_q     <= '0;
      p_rd_q     <= '0;
      PASS_COUNT <= '0;
      DROP_COUNT <= '0;
      state_q    <= S_IDLE;
    end else begin
      run_q   <= 1'b1;
      state_q <= state_d;
      if (d_push)   d_wr_q     <= d_wr_q + (DAW+1)'(1);
      if (d_pop)    d_rd_q     <= d_rd_q + (DAW+1)'(1);
      if (p_push)   p_wr_q     <= p_wr_q + (PAW+1)'(1);
      if (p_pop)    p_rd_q     <= p_rd_q + (PAW+1)'(1);
      if (pass_inc) PASS_COUNT <= PASS_COUNT + 32'd1;
      if (drop_inc) DROP_COUNT <= DROP_COUNT + 32'd1;
    end
  end

  // Read side: take a status, then forward or discard exactly one packet
  always_comb begin
    state_d  = state_q;
    p_pop    = 1'b0;
    d_pop    = 1'b0;
    tx_valid = 1'b0;
    pass_inc = 1'b0;
    drop_inc = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!ps_empty) begin
          p_pop   = 1'b1;
          state_d = ps_head ? S_DROP : S_PASS;
        end
      end
      S_PASS: begin
        tx_valid = ~data_empty;
        if (tx_valid && axis_tx.tready) begin
          d_pop = 1'b1;
          if (head_last) begin
            pass_inc = 1'b1;
            state_d  = S_IDLE;
          end
        end
      end
      S_DROP: begin
        if (!data_empty) begin
          d_pop = 1'b1;
          if (head_last) begin
            drop_inc = 1'b1;
            state_d  = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign axis_tx.tvalid = tx_valid;
  assign axis_tx.tdata  = head[ENTRY_W-1 -: DATA_WIDTH];
  assign axis_tx.tkeep  = head[KEEP_W:1];
  assign axis_tx.tlast  = tx_valid & head_last;
  assign axis_tx.tuser  = 1'b0;

endmodule

// File: tb/tb_bpf_stage2.sv
// Testbench for bpf_stage2: random packets and statuses, scoreboard of
// expected forwarded beats, counter and boundary checks.
module tb_bpf_stage2;

  localparam int unsigned DW = 512;
  localparam int unsigned KW = DW / 8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [31:0] pass_count, drop_count;

  bpf_stage2_if #(.DATA_WIDTH(DW)) rx_if ();
  bpf_stage2_if #(.DATA_WIDTH(DW)) tx_if ();
  bpf_stage2_ps_if                 ps_if ();

  bpf_stage2 #(.DATA_WIDTH(DW), .FIFO_DEPTH(64), .PS_DEPTH(16)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .axis_rx    (rx_if),
    .axis_ps    (ps_if),
    .axis_tx    (tx_if),
    .PASS_COUNT (pass_count),
    .DROP_COUNT (drop_count)
  );

  always #5 clk = ~clk;

  int    total = 0;
  int    bad   = 0;
  beat_t exp_q [$];
  beat_t stim_q [$];
  bit    st_q [$];
  int    exp_pass = 0;
  int    exp_drop = 0;
  bit    bp_mode = 1'b0;
  bit    fixed_rdy = 1'b1;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // Downstream ready: random or fixed, changed just after each rising edge
  always @(posedge clk) begin
    #1;
    tx_if.tready = bp_mode ? 1'($urandom_range(1)) : fixed_rdy;
  end

  // Monitor: compares every transferred beat and payload stability during stalls
  logic  stall_q = 1'b0;
  beat_t held;
  always @(negedge clk) begin
    beat_t cur, e;
    cur = '{data: tx_if.tdata, keep: tx_if.tkeep, last: tx_if.tlast};
    if (!resetn) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        check("stall_valid", DW'(tx_if.tvalid), DW'(1'b1));
        check("stall_payload", DW'(cur != held), DW'(1'b0));
      end
      if (tx_if.tvalid && tx_if.tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", DW'(1'b1), DW'(1'b0));
        end else begin
          e = exp_q.pop_front();
          check("tx_data", cur.data, e.data);
          check("tx_keep", DW'(cur.keep), DW'(e.keep));
          check("tx_last", DW'(cur.last), DW'(e.last));
          check("tx_user", DW'(tx_if.tuser), DW'(1'b0));
        end
      end
      stall_q = tx_if.tvalid & ~tx_if.tready;
      held    = cur;
    end
  end

  // Reference model: a good packet's beats appear on TX in status order, a bad one never does
  task automatic gen_packet(input int len, input bit is_bad);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = rand_data();
      b.last = (i == len - 1);
      b.keep = b.last ? (KW'({$urandom, $urandom}) | KW'(1)) : '1;
      stim_q.push_back(b);
      if (!is_bad) exp_q.push_back(b);
    end
    st_q.push_back(is_bad);
    if (is_bad) exp_drop++; else exp_pass++;
  endtask

  task automatic send_beat(input beat_t b);
    int n = 0;
    bit done = 1'b0;
    rx_if.tdata  = b.data;
    rx_if.tkeep  = b.keep;
    rx_if.tlast  = b.last;
    rx_if.tvalid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (rx_if.tready) begin
        @(posedge clk); #1;
        done = 1'b1;
      end else if (++n > 3000) begin
        check("rx_timeout", DW'(1'b1), DW'(1'b0));
        done = 1'b1;
      end
    end
    rx_if.tvalid = 1'b0;
  endtask

  task automatic send_status(input bit s);
    int n = 0;
    bit done = 1'b0;
    ps_if.tdata  = {7'($urandom), s};
    ps_if.tvalid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (ps_if.tready) begin
        @(posedge clk); #1;
        done = 1'b1;
      end else if (++n > 3000) begin
        check("ps_timeout", DW'(1'b1), DW'(1'b0));
        done = 1'b1;
      end
    end
    ps_if.tvalid = 1'b0;
  endtask

  task automatic drive_data(input int gap_max);
    while (stim_q.size() > 0) begin
      repeat ($urandom_range(gap_max)) begin @(posedge clk); #1; end
      send_beat(stim_q.pop_front());
    end
  endtask

  task automatic drive_status(input int delay_max);
    while (st_q.size() > 0) begin
      repeat ($urandom_range(delay_max)) begin @(posedge clk); #1; end
      send_status(st_q.pop_front());
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 5000) begin @(posedge clk); n++; end
    if (exp_q.size() != 0) check({name, "_drain_timeout"}, DW'(exp_q.size()), DW'(0));
    repeat (80) @(posedge clk);
    #1;
    check({name, "_pass_count"}, DW'(pass_count), DW'(exp_pass));
    check({name, "_drop_count"}, DW'(drop_count), DW'(exp_drop));
  endtask

  initial begin
    beat_t b;
    bit    s;
    rx_if.tvalid = 1'b0; rx_if.tlast = 1'b0; rx_if.tuser = 1'b0;
    rx_if.tdata = '0; rx_if.tkeep = '0;
    ps_if.tvalid = 1'b0; ps_if.tdata = '0;
    tx_if.tready = 1'b1;

    // Reset values
    #22;
    check("rst_rx_ready", DW'(rx_if.tready), DW'(1'b0));
    check("rst_ps_ready", DW'(ps_if.tready), DW'(1'b0));
    check("rst_tx_valid", DW'(tx_if.tvalid), DW'(1'b0));
    check("rst_tx_last", DW'(tx_if.tlast), DW'(1'b0));
    check("rst_pass", DW'(pass_count), DW'(0));
    check("rst_drop", DW'(drop_count), DW'(0));
    @(posedge clk); #1 resetn = 1'b1;
    @(negedge clk);
    check("rel_rx_ready_low", DW'(rx_if.tready), DW'(1'b0));
    @(posedge clk); #1;
    check("rel_rx_ready", DW'(rx_if.tready), DW'(1'b1));
    check("rel_ps_ready", DW'(ps_if.tready), DW'(1'b1));

    // Single good packet; status and first beat land on the same edge
    gen_packet(4, 1'b0);
    b = stim_q.pop_front();
    s = st_q.pop_front();
    rx_if.tdata = b.data; rx_if.tkeep = b.keep; rx_if.tlast = b.last; rx_if.tvalid = 1'b1;
    ps_if.tdata = {7'($urandom), s}; ps_if.tvalid = 1'b1;
    @(posedge clk); #1;
    rx_if.tvalid = 1'b0; ps_if.tvalid = 1'b0;
    check("lat_idle_valid", DW'(tx_if.tvalid), DW'(1'b0));
    @(posedge clk); #1;
    check("lat_first_valid", DW'(tx_if.tvalid), DW'(1'b1));
    drive_data(0);
    wait_drain("good1");

    // Single bad packet: drop count rises three cycles after the status pop
    gen_packet(3, 1'b1);
    drive_data(0);
    repeat (2) @(posedge clk);
    #1;
    send_status(st_q.pop_front());
    repeat (3) @(posedge clk);
    #1;
    check("bad1_drop_early", DW'(drop_count), DW'(exp_drop - 1));
    @(posedge clk); #1;
    check("bad1_drop_done", DW'(drop_count), DW'(exp_drop));
    wait_drain("bad1");

    // Back-to-back mix with skewed status
    gen_packet(2, 1'b0); gen_packet(5, 1'b1); gen_packet(1, 1'b0);
    gen_packet(1, 1'b1); gen_packet(3, 1'b0);
    fork
      drive_data(2);
      drive_status(10);
    join
    wait_drain("mix");

    // Backpressure on a 16-beat packet plus random traffic
    bp_mode = 1'b1;
    gen_packet(16, 1'b0);
    for (int i = 0; i < 8; i++) gen_packet($urandom_range(1, 12), 1'($urandom_range(1)));
    fork
      drive_data(3);
      drive_status(6);
    join
    wait_drain("bp");
    bp_mode = 1'b0;

    // Full data FIFO with status withheld
    fixed_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    gen_packet(64, 1'b0);
    drive_data(0);
    @(negedge clk);
    check("full_rx_ready", DW'(rx_if.tready), DW'(1'b0));
    fixed_rdy = 1'b1;
    drive_status(0);
    wait_drain("full");
    check("full_rx_ready_back", DW'(rx_if.tready), DW'(1'b1));

    // Reset in the middle of a forwarded packet
    gen_packet(6, 1'b0);
    drive_status(0);
    send_beat(stim_q.pop_front());
    send_beat(stim_q.pop_front());
    b = stim_q.pop_front();
    rx_if.tdata = b.data; rx_if.tkeep = b.keep; rx_if.tlast = b.last; rx_if.tvalid = 1'b1;
    #3 resetn = 1'b0;
    #1;
    check("mid_rst_tx_valid", DW'(tx_if.tvalid), DW'(1'b0));
    check("mid_rst_rx_ready", DW'(rx_if.tready), DW'(1'b0));
    check("mid_rst_pass", DW'(pass_count), DW'(0));
    check("mid_rst_drop", DW'(drop_count), DW'(0));
    rx_if.tvalid = 1'b0;
    exp_q.delete(); stim_q.delete(); st_q.delete();
    exp_pass = 0; exp_drop = 0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk); #1;
    gen_packet(6, 1'b0);
    fork
      drive_data(1);
      drive_status(4);
    join
    wait_drain("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bpf_stage2.md
# bpf_stage2

Second stage of the bad-packet filter, directly downstream of `bpf_stage1`. It consumes stage 1's data stream and its per-packet status stream (0 = good, 1 = bad). Whole packets are buffered in a data FIFO, and each status is queued in a status FIFO. Good packets are forwarded to the output stream; bad packets are discarded in full, so only clean packets reach the next stage.

## Interface
- `DATA_WIDTH`, 512, width of TDATA in bits; TKEEP is DATA_WIDTH/8.
- `FIFO_DEPTH`, 64, data FIFO depth in beats; power of 2; also the maximum packet length.
- `PS_DEPTH`, 16, status FIFO depth in entries; power of 2.
- `clk`  in  1  sole clock; all logic is rising-edge.
- `resetn`  in  1  reset is asynchronous and active-low.
- `AXIS_RX_TDATA`  in  DATA_WIDTH  packet data from stage 1.
- `AXIS_RX_TKEEP`  in  DATA_WIDTH/8  byte enables.
- `AXIS_RX_TVALID`  in  1  beat valid.
- `AXIS_RX_TLAST`  in  1  last beat of packet.
- `AXIS_RX_TUSER`  in  1  ignored; status arrives on the PS stream.
- `AXIS_RX_TREADY`  out  1  data FIFO not full.
- `AXIS_PS_TDATA`  in  8  packet status; bit 0 = bad, bits 7:1 ignored.
- `AXIS_PS_TVALID`  in  1  status valid.
- `AXIS_PS_TREADY`  out  1  status FIFO not full.
- `AXIS_TX_TDATA`  out  DATA_WIDTH  forwarded data.
- `AXIS_TX_TKEEP`  out  DATA_WIDTH/8  forwarded byte enables.
- `AXIS_TX_TVALID`  out  1  forwarded beat valid.
- `AXIS_TX_TLAST`  out  1  forwarded last beat.
- `AXIS_TX_TUSER`  out  1  tied to 0; forwarded packets are always good.
- `AXIS_TX_TREADY`  in  1  downstream ready.
- `PASS_COUNT`  out  32  count of packets forwarded; wraps modulo 2^32.
- `DROP_COUNT`  out  32  count of packets dropped; wraps modulo 2^32.

## Operation
- **Data FIFO write side**
  - Entry is {TDATA, TKEEP, TLAST}.
  - A write occurs on RX_TVALID & RX_TREADY.
  - RX_TREADY = !data_full. It depends only on occupancy; there is no full-and-read pass-through.
- **Status FIFO write side**
  - Entry is PS_TDATA[0].
  - A write occurs on PS_TVALID & PS_TREADY.
  - PS_TREADY = !ps_full.
- **Ordering**: the Nth status entry applies to the Nth packet in the data FIFO. The two streams are independent and may arrive in any relative skew.
- **Read-side FSM**: states are IDLE, PASS and DROP.
  - **IDLE**: when ps_empty = 0, pop one status. Go to DROP if the status is 1, otherwise go to PASS. TX_TVALID = 0.
  - **PASS**: TX_TVALID = !data_empty, with TX_TDATA, TX_TKEEP and TX_TLAST taken from the data FIFO head.
    - Pop the head on TX_TVALID & TX_TREADY.
    - If the popped beat has TLAST = 1, increment PASS_COUNT and go to IDLE.
  - **DROP**: pop one beat per cycle whenever !data_empty, ignoring TX_TREADY. TX_TVALID = 0.
    - If the popped beat has TLAST = 1, increment DROP_COUNT and go to IDLE.
- **Packet length constraint**: packets must be ≤ FIFO_DEPTH beats.
  - A longer packet fills the data FIFO before its status can arrive.
  - The bench treats that case as out of contract.
- **Reset**: resetn low at any time, including mid-packet:
  - both FIFOs are flushed to empty;
  - FSM goes to IDLE;
  - both counters clear;
  - any partial packet is lost.

## Timing
- **Output values during and after reset**:
  - RX_TREADY = 0 and PS_TREADY = 0 while resetn is low; both go to 1 on the first clk after release.
  - TX_TVALID = 0 and TX_TLAST = 0. TX_TDATA and TX_TKEEP are don't-care while TVALID = 0.
  - PASS_COUNT = 0 and DROP_COUNT = 0.
- **FIFO latency**: a beat written at edge N is readable (first-word-fall-through) after edge N+1. Status entries behave the same way.
- **Cut-through**: PASS may begin before the packet's TLAST has been written. Forwarding stalls on data_empty.
- **Minimum latency**: status and first beat both written at edge N:
  - IDLE pops the status at edge N+1;
  - TX_TVALID is high during cycle N+1..N+2 (registered state);
  - the first TX beat can complete at edge N+2.
- **Inter-packet gap**: one idle TX cycle between packets for the IDLE status pop. Throughput ≥ L/(L+1) beats/cycle.
- **Drop rate**: 1 beat per cycle when data is available.
- **Handshake rules**:
  - TX_TVALID, once asserted, is not deasserted and TX payload does not change until TX_TREADY.
  - TX_TVALID must not combinationally depend on TX_TREADY.
- **Simultaneous events**: a write and a read in the same cycle leave occupancy unchanged. A full FIFO with a read that cycle still shows TREADY = 0 that cycle.
- **Counter update**: counters update at the edge where the TLAST beat is popped.

## Test plan
- **Single good packet**: 4 beats, status 0 → 4 identical beats on TX with TLAST on beat 4 and TUSER = 0; PASS_COUNT = 1, DROP_COUNT = 0.
- **Single bad packet**: 3 beats, status 1 → no TX_TVALID; DROP_COUNT = 1 three cycles after the status pop; FIFOs empty.
- **Back-to-back mix**: good(2), bad(5), good(1), bad(1), good(3) with status delivered 0–10 cycles late → TX carries exactly the 2+1+3 beats in order; PASS_COUNT = 3, DROP_COUNT = 2.
- **Backpressure**: TX_TREADY toggles randomly on a 16-beat good packet → no beat lost or duplicated; payload held stable while stalled.
- **Full**: TX_TREADY = 0 and a 64-beat packet with status withheld → RX_TREADY falls after beat 64; after status 0 and TX_TREADY = 1, all 64 beats drain and RX_TREADY returns to 1.
- **Reset mid-packet**: resetn pulsed low during beat 3 of 6 of a good packet → TX_TVALID = 0 immediately; counters 0; the next complete good packet passes correctly.
